// File: rtl/operand_pipe.sv
// Operand-B select stage: forwarding mux, immediate extension and a 1-cycle output register.
// Optional forwarding-hit counter is built when OPERAND_FWD_STAT_EN is defined.
module operand_pipe #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int NFWD  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  src_sel,
    input  logic [WIDTH-1:0]      rd2,
    input  logic [IMM_W-1:0]      imm,
    input  logic [1:0]            imm_ext,
    input  logic [NFWD-1:0]       fwd_hit,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
`ifdef OPERAND_FWD_STAT_EN
    output logic [15:0]           fwd_cnt,
`endif
    output logic [WIDTH-1:0]      srcb,
    output logic                  out_valid
);

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    function automatic logic signed [WIDTH-1:0] extend_imm(
        input logic [IMM_W-1:0] raw,
        input logic [1:0]       mode
    );
        logic signed [WIDTH-1:0] res;
        case (mode)
            EXT_ZERO:  res = {{(WIDTH-IMM_W){1'b0}}, raw};
            EXT_UPPER: res = {raw, {(WIDTH-IMM_W){1'b0}}};
            // EXT_SIGN and the reserved code both sign-extend
            default:   res = {{(WIDTH-IMM_W){raw[IMM_W-1]}}, raw};
        endcase
        return res;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic signed [WIDTH-1:0] imm_ext_p0;
    logic signed [WIDTH-1:0] reg_opnd_p0;
    logic signed [WIDTH-1:0] opnd_p0;
    logic                    load_p0;

    always_comb begin
        imm_ext_p0  = extend_imm(imm, imm_ext);
        // Walk from the highest source down so the lowest-index hit wins
        reg_opnd_p0 = rd2;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_hit[k]) reg_opnd_p0 = fwd_data[k*WIDTH +: WIDTH];
        end
        opnd_p0 = src_sel ? imm_ext_p0 : reg_opnd_p0;
        load_p0 = !flush && !stall;
    end

    // ---- p0 -> p1 output register boundary ----
    logic signed [WIDTH-1:0] srcb_p1;
    logic                    vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srcb_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (flush) begin
            srcb_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (!stall) begin
            srcb_p1 <= opnd_p0;
            vld_p1  <= in_valid;
        end
    end

    assign srcb      = srcb_p1;
    assign out_valid = vld_p1;

`ifdef OPERAND_FWD_STAT_EN
    logic [15:0] fwd_cnt_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_p1 <= '0;
        end else if (load_p0 && in_valid && !src_sel && (|fwd_hit)) begin
            fwd_cnt_p1 <= sat_inc16(fwd_cnt_p1);
        end
    end

    assign fwd_cnt = fwd_cnt_p1;
`else
    logic unused_p0;
    assign unused_p0 = load_p0;
`endif

endmodule

// File: tb/tb_operand_pipe.sv
// Scoreboard bench for operand_pipe (default parameters); counter checks build only with OPERAND_FWD_STAT_EN.
module tb_operand_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        src_sel = 1'b0;
    logic [31:0] rd2 = '0;
    logic [15:0] imm = '0;
    logic [1:0]  imm_ext = '0;
    logic [1:0]  fwd_hit = '0;
    logic [63:0] fwd_data = '0;
    logic [31:0] srcb;
    logic        out_valid;
`ifdef OPERAND_FWD_STAT_EN
    logic [15:0] fwd_cnt;
`endif

    operand_pipe #(.WIDTH(32), .IMM_W(16), .NFWD(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .src_sel(src_sel), .rd2(rd2), .imm(imm),
        .imm_ext(imm_ext), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`ifdef OPERAND_FWD_STAT_EN
        .fwd_cnt(fwd_cnt),
`endif
        .srcb(srcb), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] srcb;
        logic        vld;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    logic [31:0] m_srcb = '0;
    logic        m_vld  = 1'b0;
    logic [15:0] m_cnt  = '0;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] model_ext(input logic [15:0] i, input logic [1:0] e);
        case (e)
            2'b01:   return {16'h0000, i};
            2'b10:   return {i, 16'h0000};
            default: return {{16{i[15]}}, i};
        endcase
    endfunction

    // Drives one cycle of inputs, pushes the model's post-edge state, and waits past the edge.
    task automatic drive_cycle(input logic st, input logic fl, input logic v, input logic ss,
                               input logic [31:0] r, input logic [15:0] im, input logic [1:0] ex,
                               input logic [1:0] hit, input logic [63:0] data);
        logic [31:0] opnd;
        stall = st; flush = fl; in_valid = v; src_sel = ss; rd2 = r;
        imm = im; imm_ext = ex; fwd_hit = hit; fwd_data = data;
        if (ss)          opnd = model_ext(im, ex);
        else if (hit[0]) opnd = data[31:0];
        else if (hit[1]) opnd = data[63:32];
        else             opnd = r;
        if (fl) begin
            m_srcb = '0; m_vld = 1'b0;
        end else if (!st) begin
            m_srcb = opnd; m_vld = v;
            if (v && !ss && (|hit) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        exp_q.push_back('{srcb: m_srcb, vld: m_vld, cnt: m_cnt});
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m_srcb = '0; m_vld = 1'b0; m_cnt = '0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (srcb !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: srcb=%h out_valid=%b, required 00000000/0", srcb, out_valid);
        end
`ifdef OPERAND_FWD_STAT_EN
        n_checks++;
        if (fwd_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: fwd_cnt=%h, required 0000", fwd_cnt);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_extension();
        logic [1:0] codes [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] want [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFF8001};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 1, 1, 32'hDEAD0000, 16'h8001, codes[i], 2'b11, {32'h22, 32'h33});
            exp_e = exp_q.pop_front();
            n_checks++;
            if (srcb !== want[i] || srcb !== exp_e.srcb || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ext_%0d: srcb=%h vld=%b, required %h/1", i, srcb, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [1:0]  hits [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] want [4] = '{32'h33, 32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 1, 0, 32'h11, 16'h7FFF, 2'b00, hits[i], {32'h22, 32'h33});
            exp_e = exp_q.pop_front();
            n_checks++;
            if (srcb !== want[i] || srcb !== exp_e.srcb || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fwd_%0d: srcb=%h vld=%b, required %h/1", i, srcb, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_hold_bubble();
        for (int i = 0; i < 6; i++) begin
            // cycle 0 loads, 1..3 stall, 4 stall+flush, 5 invalid load of 0x55
            drive_cycle(i inside {[1:4]}, i == 4, i != 5, 0,
                        (i == 5) ? 32'h55 : 32'hABCD, 16'h0, 2'b00, 2'b00, 64'h0);
            exp_e = exp_q.pop_front();
            n_checks++;
            if (srcb !== exp_e.srcb || out_valid !== exp_e.vld) begin
                n_fail++;
                $display("FAIL hold_%0d: srcb=%h vld=%b, required %h/%b",
                         i, srcb, out_valid, exp_e.srcb, exp_e.vld);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(0, 0, 1, 0, 32'h1234, 16'h0, 2'b00, 2'b00, 64'h0);
        exp_e = exp_q.pop_front();
        n_checks++;
        if (srcb !== 32'h1234 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_areset: srcb=%h vld=%b, required 00001234/1", srcb, out_valid);
        end
        stall = 1'b1; flush = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (srcb !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: srcb=%h vld=%b, required 00000000/0", srcb, out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_srcb = '0; m_vld = 1'b0; m_cnt = '0;
        drive_cycle(0, 0, 1, 0, 32'h9, 16'h0, 2'b00, 2'b00, 64'h0);
        exp_e = exp_q.pop_front();
        n_checks++;
        if (srcb !== 32'h9 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_areset: srcb=%h vld=%b, required 00000009/1", srcb, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [15:0] im;
        logic [1:0]  ex, hit;
        logic        ss, v, st, fl;
        for (int i = 0; i < 40; i++) begin
            r = $urandom; im = 16'($urandom); ex = 2'($urandom); hit = 2'($urandom);
            ss = 1'($urandom); v = 1'($urandom); st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 6) == 0);
            drive_cycle(st, fl, v, ss, r, im, ex, hit, {$urandom, $urandom});
            exp_e = exp_q.pop_front();
            n_checks++;
            if (srcb !== exp_e.srcb || out_valid !== exp_e.vld) begin
                n_fail++;
                $display("FAIL b2b_%0d: srcb=%h vld=%b, required %h/%b",
                         i, srcb, out_valid, exp_e.srcb, exp_e.vld);
            end
        end
    endtask

`ifdef OPERAND_FWD_STAT_EN
    task automatic test_counter();
        apply_reset();
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, 0, 32'h1, 16'h0, 2'b00, 2'(i % 3 + 1), 64'h5);
        drive_cycle(1, 0, 1, 0, 32'h1, 16'h0, 2'b00, 2'b01, 64'h5);
        drive_cycle(1, 0, 1, 0, 32'h1, 16'h0, 2'b00, 2'b10, 64'h5);
        drive_cycle(0, 1, 1, 0, 32'h1, 16'h0, 2'b00, 2'b11, 64'h5);
        drive_cycle(0, 0, 1, 1, 32'h1, 16'h0, 2'b00, 2'b11, 64'h5);
        drive_cycle(0, 0, 0, 0, 32'h1, 16'h0, 2'b00, 2'b11, 64'h5);
        exp_q.delete();
        n_checks++;
        if (fwd_cnt !== 16'd5 || fwd_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL cnt_five: fwd_cnt=%h, required 0005", fwd_cnt);
        end
        for (int i = 0; i < 65535; i++) begin
            drive_cycle(0, 0, 1, 0, 32'h1, 16'h0, 2'b00, 2'b01, 64'h5);
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (fwd_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat: fwd_cnt=%h, required FFFF", fwd_cnt);
        end
        drive_cycle(0, 0, 1, 0, 32'h1, 16'h0, 2'b00, 2'b11, 64'h5);
        exp_e = exp_q.pop_front();
        n_checks++;
        if (fwd_cnt !== 16'hFFFF || fwd_cnt !== exp_e.cnt) begin
            n_fail++;
            $display("FAIL cnt_nowrap: fwd_cnt=%h, required FFFF", fwd_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_extension();
        test_forwarding();
        test_hold_bubble();
        test_async_reset();
        test_back_to_back();
`ifdef OPERAND_FWD_STAT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
